// File: rtl/hog_pkg.sv
// Shared types and helpers for the HOG pipeline blocks.
// Holds the serializer FSM state encoding and the counter width helper.
package hog_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Word counter width: max(1, clog2(n)), so a single-word snapshot still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buffer_serializer.sv
// Captures a NUM_WORDS-wide parallel snapshot in one beat and streams it out
// word by word on a valid/ready interface, flagging the final word with o_last.
module buffer_serializer
    import hog_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*DATA_W-1:0] i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last
);

    localparam int                CNT_W    = cnt_width(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t                      state, state_next;
    logic [CNT_W-1:0]            cnt, cnt_next;
    logic [NUM_WORDS*DATA_W-1:0] snap;
    logic                        capture;
    logic                        handshake;

    assign o_valid   = (state == SEND);
    assign o_last    = (state == SEND) && (cnt == LAST_IDX);
    // Ready again during the last accepted beat so the next snapshot follows without a bubble.
    assign o_ready   = (state == IDLE) || (o_last && i_ready);
    assign capture   = i_valid && o_ready;
    assign handshake = o_valid && i_ready;
    assign o_data    = (state == SEND) ? snap[int'(cnt) * DATA_W +: DATA_W] : '0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!o_last) begin
                        cnt_next = cnt + 1'b1;
                    end else if (capture) begin
                        state_next = SEND;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Snapshot is only cleared by reset; o_data gating hides stale contents in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (capture) begin
            snap <= i_data;
        end
    end

endmodule
